// File: rtl/tcl_phase_scheduler_if.sv
// Key/switch inputs and lamp/countdown outputs of the traffic-light phase scheduler.
// Clock and reset stay outside the interface.
interface tcl_phase_scheduler_if;
  logic [1:0] Key;
  logic [1:0] Switch;
  logic [3:0] LED;
  logic [3:0] Cnt_Tens;
  logic [3:0] Cnt_Ones;
  logic [1:0] Phase;
  logic       Tick;

  modport master (
    output Key, Switch,
    input  LED, Cnt_Tens, Cnt_Ones, Phase, Tick
  );

  modport slave (
    input  Key, Switch,
    output LED, Cnt_Tens, Cnt_Ones, Phase, Tick
  );
endinterface

// File: rtl/tcl_phase_scheduler.sv
// Three-colour light phase sequencer: RED -> GREEN -> YELLOW on a prescaled tick,
// BCD countdown, pause/skip keys and night/all-red/manual modes. All outputs registered.
module tcl_phase_scheduler #(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned T_RED    = 30,
  parameter int unsigned T_GREEN  = 25,
  parameter int unsigned T_YELLOW = 5
) (
  input logic                   Sys_CLK,
  input logic                   Sys_RST,
  tcl_phase_scheduler_if.slave  bus
);

  localparam logic [1:0] PH_RED     = 2'b00;
  localparam logic [1:0] PH_GREEN   = 2'b01;
  localparam logic [1:0] PH_YELLOW  = 2'b10;
  localparam logic [1:0] PH_SPECIAL = 2'b11;

  localparam logic [1:0] MODE_NORMAL = 2'b00;
  localparam logic [1:0] MODE_NIGHT  = 2'b01;
  localparam logic [1:0] MODE_ALLRED = 2'b10;
  localparam logic [1:0] MODE_MANUAL = 2'b11;

  localparam int unsigned    PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  PRESC_MAX = PW'(TICK_DIV - 1);

  localparam logic [3:0] RED_TENS = 4'(T_RED / 10);
  localparam logic [3:0] RED_ONES = 4'(T_RED % 10);
  localparam logic [3:0] GRN_TENS = 4'(T_GREEN / 10);
  localparam logic [3:0] GRN_ONES = 4'(T_GREEN % 10);
  localparam logic [3:0] YEL_TENS = 4'(T_YELLOW / 10);
  localparam logic [3:0] YEL_ONES = 4'(T_YELLOW % 10);

  function automatic logic [1:0] next_phase(input logic [1:0] ph);
    case (ph)
      PH_RED:   next_phase = PH_GREEN;
      PH_GREEN: next_phase = PH_YELLOW;
      default:  next_phase = PH_RED;
    endcase
  endfunction

  function automatic logic [7:0] phase_dur(input logic [1:0] ph);
    case (ph)
      PH_GREEN:  phase_dur = {GRN_TENS, GRN_ONES};
      PH_YELLOW: phase_dur = {YEL_TENS, YEL_ONES};
      default:   phase_dur = {RED_TENS, RED_ONES};
    endcase
  endfunction

  logic [1:0]    key_s1, key_s2, key_hist;
  logic [1:0]    sw_s1, sw_s2;
  logic [1:0]    mode_r, phase_r;
  logic [3:0]    tens_r, ones_r;
  logic [PW-1:0] presc_r;
  logic          paused_r, flash_r, hb_r, tick_r;
  logic [2:0]    lamp_r;

  logic [1:0]    key_pulse;
  logic          mode_change, skip, pause_tgl;
  logic [1:0]    mode_nxt, phase_nxt;
  logic [3:0]    tens_nxt, ones_nxt;
  logic [PW-1:0] presc_nxt;
  logic          paused_nxt, flash_nxt, hb_nxt, tick_nxt;
  logic [2:0]    lamp_nxt;

  always_comb begin
    key_pulse   = key_s2 & ~key_hist;
    mode_change = (sw_s2 != mode_r);
    skip        = key_pulse[1] && ((mode_r == MODE_NORMAL) || (mode_r == MODE_MANUAL));
    pause_tgl   = key_pulse[0] && (mode_r == MODE_NORMAL);

    mode_nxt   = mode_r;
    phase_nxt  = phase_r;
    tens_nxt   = tens_r;
    ones_nxt   = ones_r;
    paused_nxt = paused_r;
    flash_nxt  = flash_r;
    hb_nxt     = hb_r ^ tick_r;
    if (paused_r)
      presc_nxt = presc_r;
    else if (presc_r == PRESC_MAX)
      presc_nxt = '0;
    else
      presc_nxt = presc_r + 1'b1;

    if (mode_change) begin
      mode_nxt   = sw_s2;
      presc_nxt  = '0;
      paused_nxt = 1'b0;
      flash_nxt  = 1'b1;
      if ((sw_s2 == MODE_NIGHT) || (sw_s2 == MODE_ALLRED))
        phase_nxt = PH_SPECIAL;
      else
        phase_nxt = PH_RED;
      if (sw_s2 == MODE_NORMAL)
        {tens_nxt, ones_nxt} = phase_dur(PH_RED);
      else
        {tens_nxt, ones_nxt} = '0;
    end else begin
      case (mode_r)
        MODE_NORMAL: begin
          if (pause_tgl)
            paused_nxt = ~paused_r;
          // A skip coinciding with a tick replaces the tick's countdown step entirely.
          if (skip) begin
            phase_nxt            = next_phase(phase_r);
            {tens_nxt, ones_nxt} = phase_dur(phase_nxt);
            presc_nxt            = '0;
          end else if (tick_r) begin
            if ((tens_r == 4'd0) && (ones_r == 4'd1)) begin
              phase_nxt            = next_phase(phase_r);
              {tens_nxt, ones_nxt} = phase_dur(phase_nxt);
            end else if (ones_r == 4'd0) begin
              ones_nxt = 4'd9;
              tens_nxt = tens_r - 4'd1;
            end else begin
              ones_nxt = ones_r - 4'd1;
            end
          end
        end
        MODE_MANUAL: begin
          if (skip) begin
            phase_nxt = next_phase(phase_r);
            presc_nxt = '0;
          end
        end
        MODE_NIGHT: begin
          if (tick_r)
            flash_nxt = ~flash_r;
        end
        default: ;
      endcase
    end

    // Tick is registered so it is high exactly while the prescaler sits at its last count.
    tick_nxt = !paused_nxt && (presc_nxt == PRESC_MAX);

    case (mode_nxt)
      MODE_NIGHT:  lamp_nxt = {1'b0, flash_nxt, 1'b0};
      MODE_ALLRED: lamp_nxt = 3'b001;
      default: begin
        case (phase_nxt)
          PH_GREEN:  lamp_nxt = 3'b100;
          PH_YELLOW: lamp_nxt = 3'b010;
          default:   lamp_nxt = 3'b001;
        endcase
      end
    endcase
  end

  always_ff @(posedge Sys_CLK or posedge Sys_RST) begin
    if (Sys_RST) begin
      key_s1   <= '0;
      key_s2   <= '0;
      key_hist <= '0;
      sw_s1    <= '0;
      sw_s2    <= '0;
      mode_r   <= MODE_NORMAL;
      phase_r  <= PH_RED;
      tens_r   <= RED_TENS;
      ones_r   <= RED_ONES;
      presc_r  <= '0;
      paused_r <= 1'b0;
      flash_r  <= 1'b1;
      hb_r     <= 1'b0;
      tick_r   <= 1'b0;
      lamp_r   <= 3'b001;
    end else begin
      key_s1   <= bus.Key;
      key_s2   <= key_s1;
      key_hist <= key_s2;
      sw_s1    <= bus.Switch;
      sw_s2    <= sw_s1;
      mode_r   <= mode_nxt;
      phase_r  <= phase_nxt;
      tens_r   <= tens_nxt;
      ones_r   <= ones_nxt;
      presc_r  <= presc_nxt;
      paused_r <= paused_nxt;
      flash_r  <= flash_nxt;
      hb_r     <= hb_nxt;
      tick_r   <= tick_nxt;
      lamp_r   <= lamp_nxt;
    end
  end

  assign bus.LED      = {hb_r, lamp_r};
  assign bus.Cnt_Tens = tens_r;
  assign bus.Cnt_Ones = ones_r;
  assign bus.Phase    = phase_r;
  assign bus.Tick     = tick_r;

endmodule

// File: tb/tb_tcl_phase_scheduler.sv
// Directed bench for tcl_phase_scheduler with TICK_DIV=4, T_RED=3, T_GREEN=2, T_YELLOW=1.
// Expected values are hand-derived edge counts after reset release.
module tb_tcl_phase_scheduler;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  tcl_phase_scheduler_if bus ();

  tcl_phase_scheduler #(
    .TICK_DIV (4),
    .T_RED    (3),
    .T_GREEN  (2),
    .T_YELLOW (1)
  ) dut (
    .Sys_CLK (clk),
    .Sys_RST (rst),
    .bus     (bus)
  );

  typedef struct {
    int unsigned cycles;
    logic [1:0]  key;
    logic [1:0]  sw;
    logic [1:0]  ph;
    logic [7:0]  cnt;
    logic [3:0]  led;
    logic        tick;
    string       name;
  } vec_t;

  vec_t vecs[8];

  task automatic check_full(input string name, input logic [1:0] ph, input logic [7:0] cnt,
                            input logic [3:0] led, input logic tick);
    checks++;
    if ({bus.Phase, bus.Cnt_Tens, bus.Cnt_Ones, bus.LED, bus.Tick} !== {ph, cnt, led, tick}) begin
      errors++;
      $display("FAIL %s: got phase=%b cnt=%h%h led=%b tick=%b, want phase=%b cnt=%h led=%b tick=%b",
               name, bus.Phase, bus.Cnt_Tens, bus.Cnt_Ones, bus.LED, bus.Tick, ph, cnt, led, tick);
    end
  endtask

  // Heartbeat-independent check: phase, count and the three lamps.
  task automatic check_lamps(input string name, input logic [1:0] ph, input logic [7:0] cnt,
                             input logic [2:0] lamps);
    checks++;
    if ({bus.Phase, bus.Cnt_Tens, bus.Cnt_Ones, bus.LED[2:0]} !== {ph, cnt, lamps}) begin
      errors++;
      $display("FAIL %s: got phase=%b cnt=%h%h lamps=%b, want phase=%b cnt=%h lamps=%b",
               name, bus.Phase, bus.Cnt_Tens, bus.Cnt_Ones, bus.LED[2:0], ph, cnt, lamps);
    end
  endtask

  // One-cycle key press; returns at the negedge after the edge where the action lands.
  task automatic pulse_key(input int unsigned idx);
    bus.Key[idx] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.Key[idx] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cycles(input int unsigned n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{3, 2'b00, 2'b00, 2'b00, 8'h03, 4'b0001, 1'b1, "t1_r03_tick"};
    vecs[1] = '{1, 2'b00, 2'b00, 2'b00, 8'h02, 4'b1001, 1'b0, "t1_r02"};
    vecs[2] = '{4, 2'b00, 2'b00, 2'b00, 8'h01, 4'b0001, 1'b0, "t1_r01"};
    vecs[3] = '{4, 2'b00, 2'b00, 2'b01, 8'h02, 4'b1100, 1'b0, "t1_g02"};
    vecs[4] = '{4, 2'b00, 2'b00, 2'b01, 8'h01, 4'b0100, 1'b0, "t1_g01"};
    vecs[5] = '{4, 2'b00, 2'b00, 2'b10, 8'h01, 4'b1010, 1'b0, "t1_y01"};
    vecs[6] = '{4, 2'b00, 2'b00, 2'b00, 8'h03, 4'b0001, 1'b0, "t1_r03_wrap"};
    vecs[7] = '{4, 2'b00, 2'b00, 2'b00, 8'h02, 4'b1001, 1'b0, "t1_r02_again"};

    rst        = 1'b1;
    bus.Key    = 2'b00;
    bus.Switch = 2'b00;
    repeat (3) @(negedge clk);
    check_full("reset_state", 2'b00, 8'h03, 4'b0001, 1'b0);
    rst = 1'b0;

    // Normal sequence
    for (int i = 0; i < 8; i++) begin
      bus.Key    = vecs[i].key;
      bus.Switch = vecs[i].sw;
      cycles(vecs[i].cycles);
      check_full(vecs[i].name, vecs[i].ph, vecs[i].cnt, vecs[i].led, vecs[i].tick);
    end

    // Pause at R02, hold 20 cycles, resume
    pulse_key(0);
    check_full("t2_paused", 2'b00, 8'h02, 4'b1001, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cycles(1);
      check_full("t2_frozen", 2'b00, 8'h02, 4'b1001, 1'b0);
    end
    pulse_key(0);
    check_full("t2_resume_tick", 2'b00, 8'h02, 4'b1001, 1'b1);
    cycles(1);
    check_full("t2_r01", 2'b00, 8'h01, 4'b0001, 1'b0);
    cycles(4);
    check_full("t2_g02", 2'b01, 8'h02, 4'b1100, 1'b0);

    // Skip held 10 cycles at R02
    cycles(16);
    check_full("t3_r02", 2'b00, 8'h02, 4'b1001, 1'b0);
    bus.Key = 2'b10;
    cycles(3);
    check_full("t3_skip_g02", 2'b01, 8'h02, 4'b1100, 1'b0);
    cycles(3);
    check_full("t3_presc_cleared", 2'b01, 8'h02, 4'b1100, 1'b1);
    cycles(1);
    check_full("t3_g01", 2'b01, 8'h01, 4'b0100, 1'b0);
    cycles(3);
    check_full("t3_held_no_repeat", 2'b01, 8'h01, 4'b0100, 1'b1);
    bus.Key = 2'b00;

    // Skip coincident with Tick at G01
    cycles(22);
    check_full("t6_g01", 2'b01, 8'h01, 4'b0100, 1'b0);
    pulse_key(1);
    check_full("t6_skip_tick_y01", 2'b10, 8'h01, 4'b1010, 1'b0);
    cycles(4);
    check_full("t6_next_r03", 2'b00, 8'h03, 4'b0001, 1'b0);

    // Pause, then night mode clears it
    pulse_key(0);
    check_full("t4_paused", 2'b00, 8'h03, 4'b0001, 1'b0);
    bus.Switch = 2'b01;
    cycles(3);
    check_full("t4_night_enter", 2'b11, 8'h00, 4'b0010, 1'b0);
    cycles(3);
    check_full("t4_night_tick", 2'b11, 8'h00, 4'b0010, 1'b1);
    cycles(1);
    check_full("t4_night_dark", 2'b11, 8'h00, 4'b1000, 1'b0);
    cycles(4);
    check_full("t4_night_lit", 2'b11, 8'h00, 4'b0010, 1'b0);
    bus.Switch = 2'b00;
    cycles(3);
    check_full("t4_normal_r03", 2'b00, 8'h03, 4'b0001, 1'b0);
    cycles(4);
    check_full("t4_normal_r02", 2'b00, 8'h02, 4'b1001, 1'b0);

    // All-red with skip presses ignored
    bus.Switch = 2'b10;
    cycles(3);
    check_full("t6_allred", 2'b11, 8'h00, 4'b1001, 1'b0);
    for (int i = 0; i < 3; i++) begin
      pulse_key(1);
      cycles(1);
      check_lamps("t6_allred_skip", 2'b11, 8'h00, 3'b001);
    end

    // Manual mode: skip steps the phase, count stays 00
    bus.Switch = 2'b11;
    cycles(3);
    check_lamps("manual_red", 2'b00, 8'h00, 3'b001);
    pulse_key(1);
    check_lamps("manual_green", 2'b01, 8'h00, 3'b100);
    pulse_key(1);
    check_lamps("manual_yellow", 2'b10, 8'h00, 3'b010);

    // Normal skip into GREEN, then async reset between edges
    bus.Switch = 2'b00;
    cycles(3);
    check_lamps("t5_normal_r03", 2'b00, 8'h03, 3'b001);
    pulse_key(1);
    check_lamps("t5_skip_g02", 2'b01, 8'h02, 3'b100);
    cycles(3);
    check_lamps("t5_g02_before_tick", 2'b01, 8'h02, 3'b100);
    checks++;
    if (bus.Tick !== 1'b1) begin
      errors++;
      $display("FAIL t5_tick_high: got tick=%b, want tick=1", bus.Tick);
    end
    #2;
    rst = 1'b1;
    #1;
    check_full("t5_async_reset", 2'b00, 8'h03, 4'b0001, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cycles(4);
    check_full("t5_after_reset_r02", 2'b00, 8'h02, 4'b1001, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
